// File: rtl/icache_if.sv
// Bus bundle between fetch stage / cache controller and the I-cache datapath.
// master: fetch + controller side (drives address, strobes, memory data).
// slave : datapath side (returns hit, line data, memory request).
interface icache_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0] cache_addr;
  logic [DATA_W-1:0] cache_rdata;
  logic [DATA_W-1:0] mmem_rdata;
  logic [ADDR_W-1:0] mmem_addr;
  logic [DATA_W-1:0] mmem_wdata;
  logic              ld_v;
  logic              ld_tag;
  logic              ld_data;
  logic              hit;

  modport master (
    output cache_addr, mmem_rdata, ld_v, ld_tag, ld_data,
    input  cache_rdata, mmem_addr, mmem_wdata, hit
  );

  modport slave (
    input  cache_addr, mmem_rdata, ld_v, ld_tag, ld_data,
    output cache_rdata, mmem_addr, mmem_wdata, hit
  );
endinterface

// File: rtl/icache_datapath.sv
// Instruction-cache datapath: direct-mapped, one word per line, register-based
// valid/tag/data arrays with combinational lookup and controller-driven fill.
// Optional macro ICACHE_FILL_FWD_EN: forward mmem_rdata onto cache_rdata while
// ld_data is asserted and suppress hit for that cycle.
module icache_datapath #(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int INDEX_W  = 4,
  parameter int OFFSET_W = 2
) (
  input  logic     clk,
  input  logic     rst_n,
  icache_if.slave  bus
);

  localparam int TAG_W = ADDR_W - INDEX_W - OFFSET_W;
  localparam int SETS  = 1 << INDEX_W;

  logic [SETS-1:0]   r_valid;
  logic [TAG_W-1:0]  r_tag  [SETS];
  logic [DATA_W-1:0] r_data [SETS];

  logic [INDEX_W-1:0] w_idx;
  logic [TAG_W-1:0]   w_tag;
  logic               w_lookup_hit;

  assign w_idx = bus.cache_addr[OFFSET_W +: INDEX_W];
  assign w_tag = bus.cache_addr[ADDR_W-1 -: TAG_W];

  // Array update: async clear, then independent per-array writes on the indexed set
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= '0;
      for (int unsigned i = 0; i < SETS; i++) begin
        r_tag[i]  <= '0;
        r_data[i] <= '0;
      end
    end else begin
      if (bus.ld_v)    r_valid[w_idx] <= 1'b1;
      if (bus.ld_tag)  r_tag[w_idx]   <= w_tag;
      if (bus.ld_data) r_data[w_idx]  <= bus.mmem_rdata;
    end
  end

  // Combinational lookup and read path
  always_comb begin
    w_lookup_hit    = r_valid[w_idx] && (r_tag[w_idx] == w_tag);
`ifdef ICACHE_FILL_FWD_EN
    bus.hit         = w_lookup_hit && !bus.ld_data;
    bus.cache_rdata = bus.ld_data ? bus.mmem_rdata : r_data[w_idx];
`else
    bus.hit         = w_lookup_hit;
    bus.cache_rdata = r_data[w_idx];
`endif
  end

  // Memory request side: word-aligned address, read-only cache never writes
  always_comb begin
    bus.mmem_addr  = {bus.cache_addr[ADDR_W-1:OFFSET_W], {OFFSET_W{1'b0}}};
    bus.mmem_wdata = '0;
  end

endmodule

// File: tb/tb_icache_datapath.sv
// Self-checking bench for icache_datapath: directed vector table plus
// hand-written reset / async-reset / aborted-fill sequences.
module tb_icache_datapath;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_errors;

  icache_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  icache_datapath #(
    .ADDR_W(32), .DATA_W(32), .INDEX_W(4), .OFFSET_W(2)
  ) u_dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [31:0] addr;
    logic        ld_v;
    logic        ld_tag;
    logic        ld_data;
    logic [31:0] mrd;
    logic        exp_hit;
    logic [31:0] exp_rdata;
    logic [31:0] exp_maddr;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [31:0] addr, input logic v, input logic t,
                       input logic d, input logic [31:0] mrd);
    bus.cache_addr = addr;
    bus.ld_v       = v;
    bus.ld_tag     = t;
    bus.ld_data    = d;
    bus.mmem_rdata = mrd;
  endtask

  initial begin
    logic        eh;
    logic [31:0] er;
    n_checks = 0;
    n_errors = 0;
    rst_n    = 1'b0;
    drive(32'h0000_000A, 1'b0, 1'b0, 1'b0, 32'h0);

    // ---------------- reset state ----------------
    #2;
    check("rst_hit",   {31'b0, bus.hit}, 32'h0);
    check("rst_rdata", bus.cache_rdata,  32'h0);
    check("rst_wdata", bus.mmem_wdata,   32'h0);
    check("rst_maddr", bus.mmem_addr,    32'h0000_0008);
    // strobes during reset must be ignored
    drive(32'h0000_000A, 1'b1, 1'b1, 1'b1, 32'hDEAD_BEEF);
    @(posedge clk);
    @(negedge clk);
    drive(32'h0000_000A, 1'b0, 1'b0, 1'b0, 32'h0);
    #1;
    check("rst_ignore_hit",   {31'b0, bus.hit}, 32'h0);
    check("rst_ignore_rdata", bus.cache_rdata,  32'h0);
    rst_n = 1'b1;

    // ---------------- vector table ----------------
    // expected values are the combinational outputs before the vector's edge
    //                name            addr          v     t     d     mrd           hit   rdata         maddr
    vecs.push_back('{"miss_A",       32'h0000000A, 1'b0, 1'b0, 1'b0, 32'h00000000, 1'b0, 32'h00000000, 32'h00000008});
    vecs.push_back('{"fill_A",       32'h0000000A, 1'b1, 1'b1, 1'b1, 32'hFFFE000A, 1'b0, 32'h00000000, 32'h00000008});
    vecs.push_back('{"hit_A",        32'h0000000A, 1'b0, 1'b0, 1'b0, 32'h00000000, 1'b1, 32'hFFFE000A, 32'h00000008});
    vecs.push_back('{"off_8",        32'h00000008, 1'b0, 1'b0, 1'b0, 32'h00000000, 1'b1, 32'hFFFE000A, 32'h00000008});
    vecs.push_back('{"off_B",        32'h0000000B, 1'b0, 1'b0, 1'b0, 32'h00000000, 1'b1, 32'hFFFE000A, 32'h00000008});
    vecs.push_back('{"conf_4A",      32'h0000004A, 1'b0, 1'b0, 1'b0, 32'h00000000, 1'b0, 32'hFFFE000A, 32'h00000048});
    vecs.push_back('{"fill_4A",      32'h0000004A, 1'b1, 1'b1, 1'b1, 32'h12345678, 1'b0, 32'hFFFE000A, 32'h00000048});
    vecs.push_back('{"hit_4A",       32'h0000004A, 1'b0, 1'b0, 1'b0, 32'h00000000, 1'b1, 32'h12345678, 32'h00000048});
    vecs.push_back('{"evict_A",      32'h0000000A, 1'b0, 1'b0, 1'b0, 32'h00000000, 1'b0, 32'h12345678, 32'h00000008});
    vecs.push_back('{"td_C",         32'h0000000C, 1'b0, 1'b1, 1'b1, 32'hCAFEBABE, 1'b0, 32'h00000000, 32'h0000000C});
    vecs.push_back('{"noval_C",      32'h0000000C, 1'b0, 1'b0, 1'b0, 32'h00000000, 1'b0, 32'hCAFEBABE, 32'h0000000C});
    vecs.push_back('{"v_only_C",     32'h0000000C, 1'b1, 1'b0, 1'b0, 32'hDEADBEEF, 1'b0, 32'hCAFEBABE, 32'h0000000C});
    vecs.push_back('{"hit_C",        32'h0000000C, 1'b0, 1'b0, 1'b0, 32'h00000000, 1'b1, 32'hCAFEBABE, 32'h0000000C});
    vecs.push_back('{"idx15_empty",  32'h0000003C, 1'b0, 1'b0, 1'b0, 32'h00000000, 1'b0, 32'h00000000, 32'h0000003C});
    vecs.push_back('{"fill_max",     32'hFFFFFFFF, 1'b1, 1'b1, 1'b1, 32'h55AA55AA, 1'b0, 32'h00000000, 32'hFFFFFFFC});
    vecs.push_back('{"hit_max",      32'hFFFFFFFC, 1'b0, 1'b0, 1'b0, 32'h00000000, 1'b1, 32'h55AA55AA, 32'hFFFFFFFC});
    vecs.push_back('{"idx15_tag0",   32'h0000003C, 1'b0, 1'b0, 1'b0, 32'h00000000, 1'b0, 32'h55AA55AA, 32'h0000003C});
    vecs.push_back('{"d_only_C",     32'h0000000C, 1'b0, 1'b0, 1'b1, 32'h01020304, 1'b1, 32'hCAFEBABE, 32'h0000000C});
    vecs.push_back('{"d_new_C",      32'h0000000C, 1'b0, 1'b0, 1'b0, 32'h00000000, 1'b1, 32'h01020304, 32'h0000000C});
    vecs.push_back('{"t_only_8C",    32'h0000008C, 1'b0, 1'b1, 1'b0, 32'h00000000, 1'b0, 32'h01020304, 32'h0000008C});
    vecs.push_back('{"old_tag_C",    32'h0000000C, 1'b0, 1'b0, 1'b0, 32'h00000000, 1'b0, 32'h01020304, 32'h0000000C});
    vecs.push_back('{"hit_8C",       32'h0000008C, 1'b0, 1'b0, 1'b0, 32'h00000000, 1'b1, 32'h01020304, 32'h0000008C});

    foreach (vecs[i]) begin
      drive(vecs[i].addr, vecs[i].ld_v, vecs[i].ld_tag, vecs[i].ld_data, vecs[i].mrd);
      eh = vecs[i].exp_hit;
      er = vecs[i].exp_rdata;
`ifdef ICACHE_FILL_FWD_EN
      if (vecs[i].ld_data) begin
        eh = 1'b0;
        er = vecs[i].mrd;
      end
`endif
      #1;
      check({vecs[i].name, "_hit"},   {31'b0, bus.hit}, {31'b0, eh});
      check({vecs[i].name, "_rdata"}, bus.cache_rdata,  er);
      check({vecs[i].name, "_maddr"}, bus.mmem_addr,    vecs[i].exp_maddr);
      check({vecs[i].name, "_wdata"}, bus.mmem_wdata,   32'h0);
      @(posedge clk);
      @(negedge clk);
    end

    // ---------------- async reset between edges ----------------
    drive(32'h0000008C, 1'b0, 1'b0, 1'b0, 32'h0);
    #1;
    check("pre_async_hit", {31'b0, bus.hit}, 32'h1);
    #1;
    rst_n = 1'b0;             // mid-cycle, no clock edge involved
    #1;
    check("async_hit",   {31'b0, bus.hit}, 32'h0);
    check("async_rdata", bus.cache_rdata,  32'h0);
    bus.cache_addr = 32'hFFFFFFFC;
    #1;
    check("async_max_hit", {31'b0, bus.hit}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // ---------------- fill aborted by reset ----------------
    drive(32'h0000000A, 1'b1, 1'b1, 1'b1, 32'hFFFE000A);
    #2;
    rst_n = 1'b0;             // drops before the capturing edge
    @(posedge clk);
    @(negedge clk);
    drive(32'h0000000A, 1'b0, 1'b0, 1'b0, 32'h0);
    rst_n = 1'b1;
    #1;
    check("abort_hit",   {31'b0, bus.hit}, 32'h0);
    check("abort_rdata", bus.cache_rdata,  32'h0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
